// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the transmitter state encoding, the frame data width and the default
// baud divider so a future receiver can reuse the same constants.
package uart_pkg;

    localparam int unsigned DATA_BITS       = 8;
    // 100 MHz system clock / 115200 baud
    localparam int unsigned DEFAULT_CLK_DIV = 868;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Core-side character port of the buffered UART transmitter.
// Signals:
//   din      [31:0]         character word; only din[7:0] is sent
//   we                      single-cycle write strobe
//   busy                    FIFO non-empty or frame in progress
//   full                    FIFO holds 2^FIFO_LOG2 bytes
//   overflow                sticky dropped-write flag
//   count    [FIFO_LOG2:0]  FIFO occupancy
// master: the core that writes characters; slave: the transmitter.
interface uart_tx_fifo_if #(
    parameter int unsigned FIFO_LOG2 = 4
);

    logic [31:0]        din;
    logic               we;
    logic               busy;
    logic               full;
    logic               overflow;
    logic [FIFO_LOG2:0] count;

    modport master (
        output din,
        output we,
        input  busy,
        input  full,
        input  overflow,
        input  count
    );

    modport slave (
        input  din,
        input  we,
        output busy,
        output full,
        output overflow,
        output count
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   push, din [WIDTH]     write request and data
//   pop                   read request; dout already holds the head entry
//   dout [WIDTH]          head entry (valid while empty is low)
//   count [DEPTH_LOG2:0]  occupancy
//   full, empty           status flags
// A push while full is accepted only if a pop happens on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage carries no reset; stale entries are never visible past the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    core-side character port (din/we in; busy/full/overflow/count out)
//   txd    registered serial output, idle high
// Bytes written through bus are queued in a FIFO and sent back to back; each
// bit lasts CLK_DIV clocks, so one frame takes 10*CLK_DIV clocks.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV   = DEFAULT_CLK_DIV,
    parameter int unsigned FIFO_LOG2 = 4
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_fifo_if.slave  bus,
    output logic           txd
);

    localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam logic [DIV_W-1:0] BAUD_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

    tx_state_e            state_q;
    logic [DIV_W-1:0]     baud_q;
    logic [BIT_W-1:0]     bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 txd_q;
    logic                 overflow_q;

    logic [DATA_BITS-1:0] fifo_dout;
    logic [FIFO_LOG2:0]   fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 baud_last;
    logic                 pop;

    logic unused_din;
    assign unused_din = ^bus.din[31:DATA_BITS];

    assign baud_last = (baud_q == BAUD_LAST);
    // A byte leaves the FIFO when idle, or at the end of a stop bit so frames
    // run back to back with no idle gap.
    assign pop = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && baud_last));

    sync_fifo #(
        .WIDTH      (DATA_BITS),
        .DEPTH_LOG2 (FIFO_LOG2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.we),
        .pop   (pop),
        .din   (bus.din[DATA_BITS-1:0]),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // shift_q[0] always holds the next data bit to put on the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    bit_q  <= '0;
                    txd_q  <= 1'b1;
                    if (!fifo_empty) begin
                        shift_q <= fifo_dout;
                        state_q <= START;
                        txd_q   <= 1'b0;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        txd_q   <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_q == BIT_LAST) begin
                            bit_q   <= '0;
                            txd_q   <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            txd_q   <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (!fifo_empty) begin
                            shift_q <= fifo_dout;
                            txd_q   <= 1'b0;
                            state_q <= START;
                        end else begin
                            txd_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    baud_q  <= '0;
                    bit_q   <= '0;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

    // A write into a full FIFO is only lost if no byte leaves on that edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (bus.we && fifo_full && !pop) begin
            overflow_q <= 1'b1;
        end
    end

    assign txd          = txd_q;
    assign bus.busy     = (state_q != IDLE) || (fifo_count != '0);
    assign bus.full     = fifo_full;
    assign bus.overflow = overflow_q;
    assign bus.count    = fifo_count;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered UART transmitter that consumes the core's character-output stream (uart_dout/uart_we) and serializes bytes onto a TX pin.
- Sits between the core top and the board pin.
- Contains a byte FIFO so the core can emit bursts of writes without stalling.
- Frame format is 8N1 with a parameterized baud divider.

Parameters:
CLK_DIV, 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2.
FIFO_LOG2, 4, log2 of FIFO depth (default depth 16 bytes).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
din  input  32  character word from core; only din[7:0] is transmitted, din[31:8] ignored
we  input  1  single-cycle write strobe; enqueues din[7:0]
txd  output  1  serial line, registered, idle high
busy  output  1  high while FIFO non-empty or a frame is in progress
full  output  1  FIFO holds 2^FIFO_LOG2 bytes
overflow  output  1  sticky: a write was dropped because the FIFO was full
count  output  FIFO_LOG2+1  current FIFO occupancy

Behaviour:
- Reset values: txd=1, busy=0, full=0, overflow=0, count=0, FSM in IDLE, baud and bit counters 0.
- Reset asserted mid-frame:
  - txd returns to 1 at the next edge.
  - FIFO contents are discarded.
  - overflow clears.
- Write acceptance:
  - we=1 with count < depth: byte is stored at that edge and count increments.
  - we=1 with full=1 and no pop that cycle: byte is dropped and overflow is set, held until reset.
  - we=1 on the same edge as a pop while full: the write is accepted and count is unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. When count != 0, pop the head byte into the shift register, go to START, and drive txd=0 from that edge.
  - START: hold for CLK_DIV cycles, then go to DATA with txd = bit0.
  - DATA: hold each bit for CLK_DIV cycles, LSB first, 8 bits. The bit counter runs 0..7; after bit 7 go to STOP with txd=1.
  - STOP: hold for CLK_DIV cycles. At the end:
    - count != 0: pop and go directly to START (no idle gap between frames).
    - otherwise go to IDLE.
- Baud counter runs 0..CLK_DIV-1 and resets on every state or bit transition. Every bit lasts exactly CLK_DIV cycles; a frame lasts exactly 10*CLK_DIV cycles.
- Latency: a write sampled at edge E0 into an empty FIFO with the FSM idle pops at edge E0+1, and txd falls after edge E0+1.
- busy = (state != IDLE) | (count != 0). It falls after the last stop-bit cycle when the FIFO is empty.
- full = (count == 2^FIFO_LOG2).
- FIFO pointers are FIFO_LOG2 bits wide and wrap modulo depth; count is FIFO_LOG2+1 bits.

Decomposition:
- Package uart_pkg holds:
  - the tx state enum typedef (IDLE, START, DATA, STOP);
  - DATA_BITS=8;
  - the default CLK_DIV constant, for reuse by a future receiver.
- Sub-module sync_fifo (WIDTH=8, DEPTH_LOG2=FIFO_LOG2):
  - ports push, pop, din, dout, count, full, empty;
  - first-word-fall-through output;
  - simultaneous push and pop allowed, including when full.
- uart_tx_fifo holds the FSM, baud counter, shift register and overflow flag.

Test Plan:
- CLK_DIV=4, single write din=32'h0000_0041 -> after 1 cycle txd samples 0 for 4 cycles, then 1,0,0,0,0,0,1,0 (4 cycles each), then 1 for 4 cycles; busy high for exactly 41 cycles from the write edge.
- din=32'hFFFF_FF55 -> serialized bits 1,0,1,0,1,0,1,0; upper bits are ignored.
- Three back-to-back writes 'a','b','c' on consecutive cycles -> count peaks at 2; three frames, 120 cycles total, no idle gap; start bits begin at cycles 1, 41 and 81.
- FIFO_LOG2=2, 6 consecutive writes while the first frame is in progress -> bytes 1..5 are transmitted in order, byte 6 is dropped, overflow=1 and stays 1 after the FIFO drains.
- Reset asserted at cycle 15 of a frame with 3 bytes queued -> txd=1, count=0, busy=0 next cycle; no further frames are sent.
- With the FIFO full and the FSM popping on the same edge as a write -> the write is accepted, count stays at depth, overflow stays 0.
